// File: rtl/parking_pkg.sv
// parking_pkg: gate sequencer state encoding and slot-count constants.
`default_nettype none
package parking_pkg;

  localparam int DEF_NUM_SPOTS = 4;
  localparam int SLOT_W        = $clog2(DEF_NUM_SPOTS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_OPEN   = 3'd3,
    ST_CLOSE  = 3'd4
  } gate_state_t;

endpackage
`default_nettype wire

// File: rtl/parking_exit_prio_enc.sv
// parking_exit_prio_enc: lowest-index-wins priority encoder over exit requests.
`default_nettype none
module parking_exit_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scanning high-to-low lets the lowest set bit overwrite earlier hits.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = i[W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer: arbitrates entry vs. per-slot exit requests, issues
// slot-manager commands and times the single gate's open/close sequence.
`default_nettype none
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int NUM_SPOTS    = DEF_NUM_SPOTS,
  parameter int OPEN_CYCLES  = 8,
  parameter int CLOSE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         entry_req,
  input  logic [NUM_SPOTS-1:0]         exit_req,
  input  logic [NUM_SPOTS-1:0]         spots,
  input  logic [2:0]                   capacity,
  output logic                         mgr_entry,
  output logic                         mgr_exit,
  output logic [$clog2(NUM_SPOTS)-1:0] mgr_exit_slot,
  output logic                         door_open,
  output logic                         entry_ack,
  output logic                         entry_reject,
  output logic [NUM_SPOTS-1:0]         exit_ack,
  output logic                         exit_err,
  output logic                         busy
);

  localparam int SW = $clog2(NUM_SPOTS);

  gate_state_t          state;
  logic [7:0]           timer;
  logic                 last_was_entry;
  logic [SW-1:0]        exit_idx;
  logic                 exit_valid;
  logic                 serve_entry;
  logic                 refusing;
  logic [NUM_SPOTS-1:0] exit_onehot;

  parking_exit_prio_enc #(
    .N (NUM_SPOTS),
    .W (SW)
  ) u_exit_enc (
    .req   (exit_req),
    .idx   (exit_idx),
    .valid (exit_valid)
  );

  assign serve_entry = entry_req && (!exit_valid || !last_was_entry);
  assign exit_onehot = NUM_SPOTS'(1) << exit_idx;
  // A refusal pulse is on the wire this cycle; skip arbitration so a requester
  // still holding its level for one more edge does not get a second refusal.
  assign refusing    = entry_reject || exit_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      timer          <= 8'd0;
      last_was_entry <= 1'b0;
      mgr_entry      <= 1'b0;
      mgr_exit       <= 1'b0;
      mgr_exit_slot  <= '0;
      door_open      <= 1'b0;
      entry_ack      <= 1'b0;
      entry_reject   <= 1'b0;
      exit_ack       <= '0;
      exit_err       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      mgr_entry    <= 1'b0;
      mgr_exit     <= 1'b0;
      entry_ack    <= 1'b0;
      entry_reject <= 1'b0;
      exit_ack     <= '0;
      exit_err     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!refusing) begin
            if (serve_entry) begin
              if (capacity == 3'd0) begin
                entry_reject <= 1'b1;
              end else begin
                state          <= ST_CMD;
                mgr_entry      <= 1'b1;
                entry_ack      <= 1'b1;
                last_was_entry <= 1'b1;
                busy           <= 1'b1;
              end
            end else if (exit_valid) begin
              exit_ack <= exit_onehot;
              if (!spots[exit_idx]) begin
                exit_err <= 1'b1;
              end else begin
                state          <= ST_CMD;
                mgr_exit       <= 1'b1;
                mgr_exit_slot  <= exit_idx;
                last_was_entry <= 1'b0;
                busy           <= 1'b1;
              end
            end
          end
        end
        ST_CMD: state <= ST_SETTLE;
        ST_SETTLE: begin
          state     <= ST_OPEN;
          door_open <= 1'b1;
          timer     <= 8'(OPEN_CYCLES);
        end
        ST_OPEN: begin
          if (timer <= 8'd1) begin
            state     <= ST_CLOSE;
            door_open <= 1'b0;
            timer     <= 8'(CLOSE_CYCLES);
          end else begin
            timer <= timer - 8'd1;
          end
        end
        ST_CLOSE: begin
          if (timer <= 8'd1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            timer <= 8'd0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          door_open <= 1'b0;
          busy      <= 1'b0;
          timer     <= 8'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_sequencer.sv
// tb_parking_gate_sequencer: directed vectors with hand-computed expectations.
`default_nettype none
module tb_parking_gate_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req;
  logic [3:0] exit_req;
  logic [3:0] spots;
  logic [2:0] capacity;
  logic       mgr_entry;
  logic       mgr_exit;
  logic [1:0] mgr_exit_slot;
  logic       door_open;
  logic       entry_ack;
  logic       entry_reject;
  logic [3:0] exit_ack;
  logic       exit_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  parking_gate_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .spots         (spots),
    .capacity      (capacity),
    .mgr_entry     (mgr_entry),
    .mgr_exit      (mgr_exit),
    .mgr_exit_slot (mgr_exit_slot),
    .door_open     (door_open),
    .entry_ack     (entry_ack),
    .entry_reject  (entry_reject),
    .exit_ack      (exit_ack),
    .exit_err      (exit_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called after observing cycle t+1; checks cycles t+2 .. t+13.
  task automatic chk_door_seq(input string tag);
    for (int k = 2; k <= 13; k++) begin
      step();
      chk({tag, "_door"}, 32'(door_open), 32'(k >= 3 && k <= 10));
      chk({tag, "_busy"}, 32'(busy), 32'(k < 13));
      chk({tag, "_cmd"}, 32'({mgr_entry, mgr_exit}), 32'd0);
    end
  endtask

  // Counts cycles until the next ack pulse; gap of 0 means timeout.
  task automatic wait_grant(output int gap);
    gap = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (entry_ack || (exit_ack != 4'd0)) begin
        gap = k;
        break;
      end
    end
  endtask

  initial begin
    int gap;
    reset = 1'b1; entry_req = 1'b0; exit_req = 4'd0; spots = 4'd0; capacity = 3'd4;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_outs", 32'({mgr_entry, mgr_exit, mgr_exit_slot, entry_ack, entry_reject, exit_ack, exit_err}), 32'd0);

    // Plain entry
    entry_req = 1'b1;
    step();
    chk("ent_mgr", 32'(mgr_entry), 32'd1);
    chk("ent_ack", 32'(entry_ack), 32'd1);
    chk("ent_busy", 32'(busy), 32'd1);
    entry_req = 1'b0;
    chk_door_seq("ent");

    // Entry with lot full
    capacity = 3'd0; entry_req = 1'b1;
    step();
    chk("rej_pulse", 32'(entry_reject), 32'd1);
    chk("rej_other", 32'({mgr_entry, entry_ack, door_open, busy}), 32'd0);
    entry_req = 1'b0;
    step();
    chk("rej_end", 32'({entry_reject, door_open, busy}), 32'd0);

    // Valid exit from slot 2
    capacity = 3'd3; spots = 4'b0100; exit_req = 4'b0100;
    step();
    chk("exit_mgr", 32'(mgr_exit), 32'd1);
    chk("exit_slot", 32'(mgr_exit_slot), 32'd2);
    chk("exit_ack", 32'(exit_ack), 32'b0100);
    chk("exit_noent", 32'({mgr_entry, entry_ack}), 32'd0);
    exit_req = 4'd0;
    chk_door_seq("exit");

    // Exit from an empty slot
    spots = 4'b0000; exit_req = 4'b0010;
    step();
    chk("err_pulse", 32'(exit_err), 32'd1);
    chk("err_ack", 32'(exit_ack), 32'b0010);
    chk("err_nomgr", 32'({mgr_exit, busy, door_open}), 32'd0);
    exit_req = 4'd0;
    step();
    chk("err_end", 32'({exit_err, exit_ack, busy}), 32'd0);

    // Alternating fairness from reset
    reset = 1'b1; entry_req = 1'b1; exit_req = 4'b1001; spots = 4'b1001; capacity = 3'd2;
    step();
    reset = 1'b0;
    step();
    chk("fair1_ent", 32'(entry_ack), 32'd1);
    chk("fair1_exit", 32'(exit_ack), 32'd0);
    wait_grant(gap);
    chk("fair2_gap", 32'(gap), 32'd13);
    chk("fair2_ack", 32'({entry_ack, exit_ack}), 32'b00001);
    chk("fair2_slot", 32'(mgr_exit_slot), 32'd0);
    exit_req = 4'b1000;
    wait_grant(gap);
    chk("fair3_gap", 32'(gap), 32'd13);
    chk("fair3_ack", 32'({entry_ack, exit_ack}), 32'b10000);
    wait_grant(gap);
    chk("fair4_gap", 32'(gap), 32'd13);
    chk("fair4_ack", 32'({entry_ack, exit_ack}), 32'b01000);
    chk("fair4_slot", 32'(mgr_exit_slot), 32'd3);
    entry_req = 1'b0; exit_req = 4'd0;
    for (int k = 0; k < 30 && busy; k++) step();
    chk("fair_idle", 32'(busy), 32'd0);

    // Reset three cycles into OPEN abandons the movement
    entry_req = 1'b1;
    step();
    chk("mid_ack", 32'(entry_ack), 32'd1);
    step(); step(); step(); step();
    chk("mid_open", 32'(door_open), 32'd1);
    reset = 1'b1;
    step();
    chk("mid_rst_door", 32'(door_open), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_puls", 32'({mgr_entry, mgr_exit, entry_ack, entry_reject, exit_ack, exit_err}), 32'd0);
    reset = 1'b0;
    step();
    chk("mid_regrant", 32'(entry_ack), 32'd1);
    chk("mid_regrant_mgr", 32'(mgr_entry), 32'd1);
    entry_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
